// File: rtl/m68k_bus_bridge.sv
// m68k_bus_bridge: 68000 asynchronous bus to ack-handshake stage bridge; define M68K_BRIDGE_TIMEOUT_EN for the dev_ack timeout / bus-error path
module m68k_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [22:0] cpu_addr,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  output logic        cpu_data_oe,
  input  logic        cpu_as_n,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic        cpu_rw,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  output logic [23:0] dev_addr,
  output logic [15:0] dev_data_write,
  input  logic [15:0] dev_data_read,
  output logic        dev_uds,
  output logic        dev_lds,
  output logic        dev_rw,
  input  logic        dev_ack
);
`ifdef M68K_BRIDGE_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, REQ, ACKED, ERR} state_t;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
`else
  typedef enum logic [1:0] {IDLE, REQ, ACKED} state_t;
  localparam logic BERR_IDLE = TIMEOUT_CYCLES > 0;
  assign cpu_berr_n = BERR_IDLE;
`endif
  state_t state;
  logic [2:0] sync1, sync2;
  logic as_s, uds_s, lds_s;
  assign {as_s, uds_s, lds_s} = sync2;
  // two-flop synchronizers for AS/UDS/LDS; idle value is high (negated)
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {cpu_as_n, cpu_uds_n, cpu_lds_n};
      sync2 <= sync1;
    end
  end
  // access FSM: latch CPU cycle, hold dev request until ack, then DTACK until AS negates
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cpu_dtack_n    <= 1'b1;
      cpu_data_oe    <= 1'b0;
      cpu_data_out   <= '0;
      dev_uds        <= 1'b0;
      dev_lds        <= 1'b0;
      dev_rw         <= 1'b1;
      dev_addr       <= '0;
      dev_data_write <= '0;
`ifdef M68K_BRIDGE_TIMEOUT_EN
      cpu_berr_n     <= 1'b1;
      tmo_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (!as_s && (!uds_s || !lds_s)) begin
          state          <= REQ;
          dev_addr       <= {cpu_addr, 1'b0};
          dev_data_write <= cpu_data_in;
          dev_rw         <= cpu_rw;
          dev_uds        <= !uds_s;
          dev_lds        <= !lds_s;
`ifdef M68K_BRIDGE_TIMEOUT_EN
          tmo_cnt        <= '0;
`endif
        end
        REQ: begin
          if (dev_ack) begin
            state        <= ACKED;
            dev_uds      <= 1'b0;
            dev_lds      <= 1'b0;
            cpu_dtack_n  <= 1'b0;
            cpu_data_oe  <= dev_rw;
            cpu_data_out <= dev_rw ? dev_data_read : cpu_data_out;
          end
`ifdef M68K_BRIDGE_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state      <= ERR;
            dev_uds    <= 1'b0;
            dev_lds    <= 1'b0;
            cpu_berr_n <= 1'b0;
          end else
            tmo_cnt <= tmo_cnt + 16'd1;
`endif
        end
        ACKED: if (as_s) begin
          state       <= IDLE;
          cpu_dtack_n <= 1'b1;
          cpu_data_oe <= 1'b0;
        end
`ifdef M68K_BRIDGE_TIMEOUT_EN
        ERR: if (as_s) begin
          state      <= IDLE;
          cpu_berr_n <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m68k_bus_bridge.sv
// tb_m68k_bus_bridge: scoreboard bench driving random 68000 accesses against a word-memory reference model
module tb_m68k_bus_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [22:0] cpu_addr = '0;
  logic [15:0] cpu_data_in = '0;
  logic cpu_as_n = 1'b1, cpu_uds_n = 1'b1, cpu_lds_n = 1'b1, cpu_rw = 1'b1;
  logic [15:0] cpu_data_out, dev_data_write;
  logic cpu_data_oe, cpu_dtack_n, cpu_berr_n, dev_uds, dev_lds, dev_rw;
  logic [23:0] dev_addr;
  logic [15:0] dev_data_read = '0;
  logic dev_ack = 1'b0;
  bit dev_en = 1'b1;
  int cyc = 0, tests = 0, fails = 0;
  logic [15:0] dev_mem [8];
  logic [15:0] mdl_mem [8];
  typedef struct {
    logic [23:0] addr;
    logic rw, uds, lds;
    logic [15:0] wdata, rdata;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  m68k_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe), .cpu_as_n(cpu_as_n),
    .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw),
    .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n), .dev_addr(dev_addr),
    .dev_data_write(dev_data_write), .dev_data_read(dev_data_read),
    .dev_uds(dev_uds), .dev_lds(dev_lds), .dev_rw(dev_rw), .dev_ack(dev_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_chk();
    chk("rst_dtack_n", cpu_dtack_n, 1);
    chk("rst_berr_n", cpu_berr_n, 1);
    chk("rst_data_oe", cpu_data_oe, 0);
    chk("rst_dev_uds", dev_uds, 0);
    chk("rst_dev_lds", dev_lds, 0);
    chk("rst_dev_rw", dev_rw, 1);
    chk("rst_dev_addr", dev_addr, 0);
    chk("rst_dev_data_write", dev_data_write, 0);
    chk("rst_cpu_data_out", cpu_data_out, 0);
  endtask

  task automatic start(input logic [22:0] a, input logic rw, input logic un, input logic ln,
                       input logic [15:0] wd, output exp_t e);
    cpu_addr = a; cpu_data_in = wd; cpu_rw = rw;
    cpu_as_n = 1'b0; cpu_uds_n = un; cpu_lds_n = ln;
    e.addr = {a, 1'b0}; e.rw = rw; e.uds = !un; e.lds = !ln;
    e.wdata = wd; e.rdata = mdl_mem[a[2:0]]; e.cyc = cyc;
    if (!rw && !un) mdl_mem[a[2:0]][15:8] = wd[15:8];
    if (!rw && !ln) mdl_mem[a[2:0]][7:0] = wd[7:0];
    exp_q.push_back(e);
  endtask

  task automatic release_bus();
    cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
  endtask

  task automatic wait_strobes();
    int n = 0;
    while (!(dev_uds || dev_lds) && n < 50) begin @(negedge clk); n++; end
    chk("req_entry", dev_uds || dev_lds, 1);
  endtask

  task automatic finish_access();
    int n = 0;
    while (cpu_dtack_n && n < 50) begin @(negedge clk); n++; end
    chk("dtack_assert", cpu_dtack_n, 0);
    release_bus();
    n = 0;
    while (!cpu_dtack_n && n < 50) begin @(negedge clk); n++; end
    chk("dtack_release", cpu_dtack_n, 1);
  endtask

  task automatic access(input logic [22:0] a, input logic rw, input logic un, input logic ln,
                        input logic [15:0] wd, input bit abort);
    exp_t e;
    @(negedge clk);
    start(a, rw, un, ln, wd, e);
    if (abort) begin
      wait_strobes();
      release_bus();
    end
    finish_access();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // downstream stage: word memory answering each strobe burst after 0..3 cycles, plus stray acks afterwards
  initial begin
    foreach (dev_mem[i]) dev_mem[i] = '0;
    forever begin
      @(negedge clk iff ((dev_uds || dev_lds) && dev_en));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (dev_rw) dev_data_read = dev_mem[dev_addr[3:1]];
      else begin
        if (dev_uds) dev_mem[dev_addr[3:1]][15:8] = dev_data_write[15:8];
        if (dev_lds) dev_mem[dev_addr[3:1]][7:0] = dev_data_write[7:0];
      end
      dev_ack = 1'b1;
      @(negedge clk);
      dev_ack = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        dev_data_read = 16'($urandom);
        dev_ack = 1'b1;
        @(negedge clk);
        dev_ack = 1'b0;
      end
    end
  end

  // monitor: pops an expectation on each dev strobe rise and checks the whole access against it
  initial begin
    exp_t cur;
    bit have;
    logic prev;
    have = 1'b0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        continue;
      end
      if ((dev_uds || dev_lds) && !prev) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_access: got dev_addr 0x%0h expected no access", dev_addr);
        end else begin
          cur = exp_q.pop_front();
          have = 1'b1;
          chk("strobe_latency", cyc - cur.cyc, 3);
        end
      end
      if (have && (dev_uds || dev_lds)) begin
        chk("dev_addr", dev_addr, cur.addr);
        chk("dev_rw", dev_rw, cur.rw);
        chk("dev_uds", dev_uds, cur.uds);
        chk("dev_lds", dev_lds, cur.lds);
        chk("dev_data_write", dev_data_write, cur.wdata);
      end
      if (!cpu_dtack_n) begin
        chk("strobes_clear_on_ack", {dev_uds, dev_lds}, 0);
        if (have && cur.rw) chk("cpu_data_out", cpu_data_out, cur.rdata);
      end
      chk("cpu_data_oe", cpu_data_oe, have && !cpu_dtack_n && cur.rw);
      prev = dev_uds || dev_lds;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int k;
    foreach (mdl_mem[i]) mdl_mem[i] = '0;
    repeat (3) @(negedge clk);
    reset_chk();
    reset = 1'b0;
    access(23'h000800, 1'b0, 1'b0, 1'b0, 16'h4E71, 1'b0);
    access(23'h000800, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    access(23'h000000, 1'b0, 1'b0, 1'b0, 16'hA9A9, 1'b0);
    access(23'h000001, 1'b0, 1'b1, 1'b0, 16'h0012, 1'b0);
    access(23'h000001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    access(23'h000000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 2);
      access({20'($urandom), 3'($urandom)}, 1'($urandom), k == 1, k == 2,
             16'($urandom), $urandom_range(0, 3) == 0);
    end
    dev_en = 1'b0;
    @(negedge clk);
    start(23'h000402, 1'b1, 1'b0, 1'b0, 16'h0000, e);
    wait_strobes();
`ifdef M68K_BRIDGE_TIMEOUT_EN
    repeat (3) @(negedge clk);
    chk("berr_before_limit", cpu_berr_n, 1);
    @(negedge clk);
    chk("berr_at_limit", cpu_berr_n, 0);
    chk("berr_strobes_clear", {dev_uds, dev_lds}, 0);
    chk("dtack_in_err", cpu_dtack_n, 1);
    release_bus();
    k = 0;
    while (!cpu_berr_n && k < 20) begin @(negedge clk); k++; end
    chk("berr_release", cpu_berr_n, 1);
    dev_en = 1'b1;
`else
    repeat (20) @(negedge clk);
    chk("no_berr", cpu_berr_n, 1);
    chk("req_held", dev_uds || dev_lds, 1);
    dev_en = 1'b1;
    finish_access();
`endif
    repeat (2) @(negedge clk);
    dev_en = 1'b0;
    @(negedge clk);
    start(23'h000403, 1'b0, 1'b0, 1'b0, 16'($urandom), e);
    wait_strobes();
    reset = 1'b1;
    @(negedge clk);
    reset_chk();
    reset = 1'b0;
    e.cyc = cyc;
    exp_q.push_back(e);
    dev_en = 1'b1;
    finish_access();
    access(23'h000403, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/m68k_bus_bridge.md
M68K_BUS_BRIDGE -- requirements
Module: m68k_bus_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 255, dev_ack wait cycles before bus error (range 2..65535).
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cpu_addr  in  23  CPU A23..A1, asynchronous.
REQ-005 cpu_data_in  in  16  CPU write data D15..D0.
REQ-006 cpu_data_out  out  16  read data driven to CPU.
REQ-007 cpu_data_oe  out  1  high = bridge drives CPU data bus.
REQ-008 cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw  in  1 each  CPU bus controls, asynchronous; cpu_rw high = read.
REQ-009 cpu_dtack_n  out  1  data acknowledge to CPU, active-low.
REQ-010 cpu_berr_n  out  1  bus error to CPU, active-low.
REQ-011 dev_addr  out  24  byte address {cpu_addr,1'b0} to boot/SRAM stage.
REQ-012 dev_data_write  out  16  latched write data.
REQ-013 dev_data_read  in  16  read data from boot/SRAM stage.
REQ-014 dev_uds, dev_lds, dev_rw  out  1 each  active-high byte strobes; dev_rw high = read.
REQ-015 dev_ack  in  1  active-high completion from downstream stage.

Function
REQ-016 cpu_as_n, cpu_uds_n, cpu_lds_n SHALL pass through two-flop synchronizers; FSM uses only synchronized copies.
REQ-017 FSM states: IDLE, REQ, ACKED, ERR (ERR only with macro, REQ-031).
REQ-018 IDLE->REQ when synced AS low and at least one synced data strobe low; same edge latches dev_addr, dev_data_write, dev_rw=cpu_rw, dev_uds=~uds_n, dev_lds=~lds_n.
REQ-019 Latency: strobe low at CPU pins before edge 1 -> dev strobes high after edge 3.
REQ-020 REQ: dev strobes, addr, data, rw held stable until dev_ack sampled high.
REQ-021 REQ with dev_ack high at edge k: at edge k dev strobes cleared, cpu_data_out<=dev_data_read (reads only), cpu_dtack_n<=0, state->ACKED.
REQ-022 cpu_data_oe SHALL be high only in ACKED with dev_rw=1; low in all other states and for writes.
REQ-023 ACKED->IDLE when synced AS high; same edge cpu_dtack_n<=1, cpu_data_oe<=0.
REQ-024 dev_uds and dev_lds SHALL be low for at least one full cycle between consecutive accesses (downstream detects 11->00 strobe edge).
REQ-025 dev_ack high in IDLE or ACKED SHALL be ignored.
REQ-026 AS returning high while in REQ (CPU abort) SHALL be ignored; access completes, then ACKED->IDLE next cycle.
REQ-027 Outputs registered; no combinational path from any input to any output.

Reset
REQ-028 reset high at an edge SHALL force IDLE regardless of state, including mid-access.
REQ-029 Reset values: cpu_dtack_n=1, cpu_berr_n=1, cpu_data_oe=0, dev_uds=0, dev_lds=0, dev_rw=1, dev_addr=0, dev_data_write=0, cpu_data_out=0, synchronizer flops=1, timeout counter=0.
REQ-030 After reset release, an access already in progress (AS low) SHALL start REQ only after synced strobes seen low in IDLE.

Configuration
REQ-031 Macro M68K_BRIDGE_TIMEOUT_EN defined: 16-bit counter cleared on entry to REQ, increments each REQ cycle; reaching TIMEOUT_CYCLES without dev_ack -> dev strobes cleared, cpu_berr_n<=0, state ERR; ERR->IDLE when synced AS high, cpu_berr_n<=1; dev_ack on the terminal-count edge wins (normal ACKED).
REQ-032 Macro undefined: no counter or ERR state; REQ waits indefinitely; cpu_berr_n tied 1.

Verification
REQ-033 Read 0x001000, dev_ack 2 cycles after dev strobes -> dev_addr=0x001000, dev_rw=1, cpu_data_out=dev_data_read (e.g. 0x4E71), dtack_n low until AS high, oe high only in ACKED.
REQ-034 Write word 0xA9A9 to 0x000000 -> dev_uds=dev_lds=1, dev_data_write=0xA9A9, dev_rw=0, oe stays 0.
REQ-035 Byte write 0x12 odd address (uds_n=1, lds_n=0) -> dev_uds=0, dev_lds=1; back-to-back accesses show >=1 idle cycle with both strobes low.
REQ-036 Reset asserted mid-REQ -> next edge all outputs at REQ-029 values, state IDLE.
REQ-037 Macro defined, TIMEOUT_CYCLES=4, dev_ack never -> berr_n low after 4 REQ cycles, dev strobes cleared, berr_n high after AS high; macro undefined -> no berr, REQ held.
